// File: rtl/alu.sv
// RV32 integer ALU for the execute stage: zero-latency decode/compute of result and
// error, plus a registered copy of both for pipeline capture.
module alu #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic [6:0]      opcode_i,
   input  logic [2:0]      func3_i,
   input  logic [6:0]      func7_i,
   output logic [XLEN-1:0] result_o,
   output logic            error_o,
   output logic [XLEN-1:0] result_r_o,
   output logic            error_r_o
);

   localparam int          SHW     = $clog2(XLEN);
   localparam logic [6:0]  OPC_OP  = 7'b0110011;
   localparam logic [6:0]  OPC_IMM = 7'b0010011;
   localparam logic [6:0]  F7_ZERO = 7'b0000000;
   localparam logic [6:0]  F7_ALT  = 7'b0100000;

   logic signed [XLEN-1:0] data1_s;
   logic signed [XLEN-1:0] data2_s;
   logic [SHW-1:0]         shamt;
   logic                   is_op;
   logic                   is_imm;
   logic                   f7_zero;
   logic                   f7_alt;
   logic [XLEN-1:0]        result_d;
   logic                   error_d;
   logic [XLEN-1:0]        result_q;
   logic                   error_q;

   assign data1_s = data1_i;
   assign data2_s = data2_i;
   assign shamt   = data2_i[SHW-1:0];
   assign is_op   = (opcode_i == OPC_OP);
   assign is_imm  = (opcode_i == OPC_IMM);
   assign f7_zero = (func7_i == F7_ZERO);
   assign f7_alt  = (func7_i == F7_ALT);

   // ADD is the func7=0100000 encoding and SUB the func7=0 one in OP; OP-IMM always adds.
   always_comb begin
      result_d = '0;
      error_d  = 1'b1;
      if (is_op || is_imm) begin
         unique case (func3_i)
            3'b000: begin
               if (is_imm || f7_alt) begin
                  result_d = data1_i + data2_i;
                  error_d  = 1'b0;
               end else if (f7_zero) begin
                  result_d = data1_i - data2_i;
                  error_d  = 1'b0;
               end
            end
            3'b001: begin
               if (f7_zero) begin
                  result_d = data1_i << shamt;
                  error_d  = 1'b0;
               end
            end
            3'b010: begin
               if (is_imm || f7_zero) begin
                  result_d = {{(XLEN-1){1'b0}}, (data1_s < data2_s)};
                  error_d  = 1'b0;
               end
            end
            3'b011: begin
               if (is_imm || f7_zero) begin
                  result_d = {{(XLEN-1){1'b0}}, (data1_i < data2_i)};
                  error_d  = 1'b0;
               end
            end
            3'b100: begin
               if (is_imm || f7_zero) begin
                  result_d = data1_i ^ data2_i;
                  error_d  = 1'b0;
               end
            end
            3'b101: begin
               if (f7_zero) begin
                  result_d = data1_i >> shamt;
                  error_d  = 1'b0;
               end else if (f7_alt) begin
                  result_d = data1_s >>> shamt;
                  error_d  = 1'b0;
               end
            end
            3'b110: begin
               if (is_imm || f7_zero) begin
                  result_d = data1_i | data2_i;
                  error_d  = 1'b0;
               end
            end
            3'b111: begin
               if (is_imm || f7_zero) begin
                  result_d = data1_i & data2_i;
                  error_d  = 1'b0;
               end
            end
            default: begin
               result_d = '0;
               error_d  = 1'b1;
            end
         endcase
      end
   end

   assign result_o = result_d;
   assign error_o  = error_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   assign result_r_o = result_q;
   assign error_r_o  = error_q;

endmodule

// File: tb/tb_alu.sv
// Directed and table-driven bench for the RV32 ALU: combinational and registered
// outputs, plus asynchronous reset behaviour on the registered copy.
module tb_alu;

   localparam logic [6:0] OP  = 7'b0110011;
   localparam logic [6:0] IMM = 7'b0010011;
   localparam logic [6:0] Z7  = 7'b0000000;
   localparam logic [6:0] A7  = 7'b0100000;

   typedef struct {
      string       name;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [31:0] result;
   logic        error;
   logic [31:0] result_r;
   logic        error_r;

   int passed;
   int total;
   vec_t vq[$];

   alu dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .data1_i    (data1),
      .data2_i    (data2),
      .opcode_i   (opcode),
      .func3_i    (func3),
      .func7_i    (func7),
      .result_o   (result),
      .error_o    (error),
      .result_r_o (result_r),
      .error_r_o  (error_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
   endtask

   function automatic vec_t mk(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic err);
      vec_t v;
      v.name = nm; v.opc = opc; v.f3 = f3; v.f7 = f7;
      v.a = a; v.b = b; v.res = res; v.err = err;
      return v;
   endfunction

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
      opcode = opc; func3 = f3; func7 = f7; data1 = a; data2 = b;
   endtask

   initial begin
      logic [31:0] ra, rb;
      passed = 0;
      total  = 0;
      rst_n  = 1'b1;
      drive(OP, 3'b000, A7, 32'd3, 32'd4);

      // Directed table
      vq.push_back(mk("add_wrap", OP, 3'b000, A7, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0));
      vq.push_back(mk("sub",      OP, 3'b000, Z7, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0));
      vq.push_back(mk("xor",      OP, 3'b100, Z7, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0));
      vq.push_back(mk("or",       OP, 3'b110, Z7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0));
      vq.push_back(mk("and",      OP, 3'b111, Z7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0));
      vq.push_back(mk("sll",      OP, 3'b001, Z7, 32'h00000001, 32'h0000000F, 32'h00008000, 1'b0));
      vq.push_back(mk("srl",      OP, 3'b101, Z7, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0));
      vq.push_back(mk("sra",      OP, 3'b101, A7, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0));
      vq.push_back(mk("sll_sh21", OP, 3'b001, Z7, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0));
      vq.push_back(mk("srl_sh21", OP, 3'b101, Z7, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0));
      vq.push_back(mk("sra_sh21", OP, 3'b101, A7, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0));
      vq.push_back(mk("sra_sh0",  OP, 3'b101, A7, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0));
      vq.push_back(mk("slt_neg",  OP, 3'b010, Z7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0));
      vq.push_back(mk("sltu_big", OP, 3'b011, Z7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0));
      vq.push_back(mk("slt_pos",  OP, 3'b010, Z7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0));
      vq.push_back(mk("sltu_sml", OP, 3'b011, Z7, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0));
      vq.push_back(mk("bad_opc",  7'b1111111, 3'b000, A7, 32'h00000003, 32'h00000004, 32'h0, 1'b1));
      vq.push_back(mk("and_f7alt", OP, 3'b111, A7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1));
      vq.push_back(mk("add_f7bad", OP, 3'b000, 7'b0000001, 32'h1, 32'h1, 32'h0, 1'b1));
      vq.push_back(mk("sltu_f7alt", OP, 3'b011, A7, 32'h1, 32'h2, 32'h0, 1'b1));
      vq.push_back(mk("addi",     IMM, 3'b000, 7'h7F, 32'd10, 32'd20, 32'd30, 1'b0));
      vq.push_back(mk("slti",     IMM, 3'b010, 7'h55, 32'hFFFFFFFE, 32'd3, 32'd1, 1'b0));
      vq.push_back(mk("xori",     IMM, 3'b100, 7'h20, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0));
      vq.push_back(mk("slli_bad", IMM, 3'b001, A7, 32'h1, 32'h1, 32'h0, 1'b1));
      vq.push_back(mk("srai",     IMM, 3'b101, A7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0));
      vq.push_back(mk("srli_bad", IMM, 3'b101, 7'b0000001, 32'h80000000, 32'h1, 32'h0, 1'b1));
      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = $urandom;
         vq.push_back(mk("rnd_add", OP, 3'b000, A7, ra, rb, (ra + rb), 1'b0));
         vq.push_back(mk("rnd_sub", OP, 3'b000, Z7, ra, rb, (ra - rb), 1'b0));
         vq.push_back(mk("rnd_xor", OP, 3'b100, Z7, ra, rb, (ra ^ rb), 1'b0));
         vq.push_back(mk("rnd_or",  OP, 3'b110, Z7, ra, rb, (ra | rb), 1'b0));
         vq.push_back(mk("rnd_and", OP, 3'b111, Z7, ra, rb, (ra & rb), 1'b0));
      end

      // Reset: registered outputs forced and held at zero
      #3 rst_n = 1'b0;
      #1;
      chk("rst_result_r", result_r, 32'h0);
      chk("rst_error_r", {31'b0, error_r}, 32'h0);
      chk("rst_comb_result", result, 32'd7);
      @(posedge clk); #1;
      chk("rst_hold_result_r", result_r, 32'h0);
      #2 rst_n = 1'b1;

      // Table sweep: combinational then registered after one edge
      foreach (vq[i]) begin
         drive(vq[i].opc, vq[i].f3, vq[i].f7, vq[i].a, vq[i].b);
         #1;
         chk({vq[i].name, "_res"}, result, vq[i].res);
         chk({vq[i].name, "_err"}, {31'b0, error}, {31'b0, vq[i].err});
         @(posedge clk); #1;
         chk({vq[i].name, "_res_r"}, result_r, vq[i].res);
         chk({vq[i].name, "_err_r"}, {31'b0, error_r}, {31'b0, vq[i].err});
      end

      // Async reset mid-cycle clears registered copy without a clock edge
      drive(OP, 3'b000, A7, 32'd3, 32'd4);
      @(posedge clk); #1;
      chk("seq_add_r", result_r, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("seq_async_rst_r", result_r, 32'h0);
      chk("seq_comb_in_rst", result, 32'd7);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("seq_after_rst_r", result_r, 32'd7);

      // Error captured then cleared by reset
      drive(7'b1111111, 3'b000, Z7, 32'd1, 32'd1);
      @(posedge clk); #1;
      chk("seq_err_r", {31'b0, error_r}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("seq_err_rst", {31'b0, error_r}, 32'h0);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Integer arithmetic/logic unit for the simply5 RV32 core execute stage.
- Decodes opcode/func3/func7 and computes a 32-bit result from two operands.
- Result and error are combinational, zero-latency. A registered copy of both is also provided for pipeline capture.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  input  1  clock; registered outputs update on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- data1_i  input  32  operand A (rs1).
- data2_i  input  32  operand B (rs2, or an already sign-extended immediate for OP-IMM).
- opcode_i  input  7  instruction opcode.
- func3_i  input  3  instruction funct3.
- func7_i  input  7  instruction funct7 (imm[11:5] for OP-IMM shifts).
- result_o  output  32  combinational result.
- error_o  output  1  combinational; 1 = unsupported opcode/funct combination.
- result_r_o  output  32  result_o registered.
- error_r_o  output  1  error_o registered.

Behaviour:
- Combinational path: result_o/error_o settle within the same delta/cycle as an input change. No clock is needed for result_o/error_o.
- shamt = data2_i[4:0]. Bits [31:5] of data2_i are ignored for shifts.
- OP (opcode 0110011), func3 / func7 decoding:
  - 000 with func7=0100000: ADD, data1+data2 mod 2^32.
  - 000 with func7=0000000: SUB, data1-data2 mod 2^32 (team encoding; fixed).
  - 001 with func7=0000000: SLL, data1 << shamt, zero fill.
  - 010 with func7=0000000: SLT, signed compare, result 1 or 0.
  - 011 with func7=0000000: SLTU, unsigned compare, result 1 or 0.
  - 100 with func7=0000000: XOR.
  - 101 with func7=0000000: SRL, logical right shift.
  - 101 with func7=0100000: SRA, arithmetic right shift.
  - 110 with func7=0000000: OR.
  - 111 with func7=0000000: AND.
- OP-IMM (opcode 0010011):
  - func3 000 (ADDI), 010, 011, 100, 110, 111: same as the R-type ops but func7 is ignored; 000 always adds.
  - func3 001 requires func7=0000000.
  - func3 101 requires func7=0000000 (SRLI) or 0100000 (SRAI).
- Any other opcode, or any func7 value not listed above: error_o=1, result_o=32'h0.
- Overflow/carry: ignored, wrap modulo 2^32, no flag.
- Registered path:
  - On each rising clk_i: result_r_o<=result_o, error_r_o<=error_o.
  - On rst_ni low (asynchronous, immediate): result_r_o=0, error_r_o=0.
  - Held at 0 while rst_ni is low; first capture on the first rising edge after deassertion.
- Reset does not affect the combinational outputs.
- X-free: all decode paths assign both outputs (default 0/error).

Test Plan:
- ADD: opcode=0110011, func3=000, func7=0100000, data1=FFFFFFFF, data2=00000002 -> result_o=00000001, error_o=0. Repeat 10 random pairs against a mod-2^32 sum.
- SUB: func7=0000000, data1=00000005, data2=00000007 -> result_o=FFFFFFFE. Random pairs against mod-2^32 difference.
- Logic: data1=F0F0F0F0, data2=FF00FF00 -> XOR (100)=0FF00FF0, OR (110)=FFF0FFF0, AND (111)=F000F000. Randomised with fully parenthesised compares.
- Shifts:
  - SLL (001) data1=00000001, data2=0000000F -> 00008000.
  - SRL (101/0000000) data1=80000000, data2=4 -> 08000000.
  - SRA (101/0100000) same inputs -> F8000000.
  - data2=00000021 uses shamt=1.
- Compare/error:
  - SLT data1=FFFFFFFF, data2=1 -> 1.
  - SLTU same inputs -> 0.
  - opcode=1111111 -> error_o=1, result_o=0.
  - func3=111 with func7=0100000 in OP -> error_o=1.
- Registered/reset: drive ADD 3+4 and clock -> result_r_o=7. Assert rst_ni mid-cycle -> result_r_o=0 immediately, without a clock edge. Deassert and clock -> result_r_o=7.
